// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter, LSB first, fed from a small byte FIFO through a valid/ready write port.
// First start bit reaches txd two edges after a write into an empty idle block; wready drops only when the FIFO is full.
module uart_tx_fifo #(
    parameter int CLK_DIV = 104,
    parameter int FIFO_AW = 2
) (
    input  logic               c,
    input  logic               r,
    input  logic [7:0]         wdata,
    input  logic               wvalid,
    output logic               wready,
    output logic               txd,
    output logic               busy,
    output logic [FIFO_AW:0]   level
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]   DIV_LOAD   = DIV_W'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0]   LEVEL_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LEVEL_ONE  = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE    = FIFO_AW'(1);
    localparam logic [DIV_W-1:0]   DIV_ONE    = DIV_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               txd_q, txd_d;
    logic [FIFO_AW:0]   level_q, level_d;
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]         mem_q [DEPTH];

    logic push;
    logic pop;
    logic tick;
    logic have_data;

    // wready looks only at the registered level, so a full FIFO refuses a write even on a pop edge.
    assign wready    = (level_q != LEVEL_FULL);
    assign push      = wvalid & wready;
    assign tick      = (div_q == '0);
    assign have_data = (level_q != '0);

    assign txd   = txd_q;
    assign level = level_q;
    assign busy  = (state_q != IDLE) | have_data;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (have_data) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    div_d   = DIV_LOAD;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    div_d   = DIV_LOAD;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            DATA: begin
                if (tick) begin
                    div_d   = DIV_LOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            STOP: begin
                if (tick) begin
                    // Chain straight into the next start bit so queued bytes leave with no idle gap.
                    if (have_data) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        div_d   = DIV_LOAD;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // The line follows the state one edge later, which keeps txd a plain flop output.
        case (state_q)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[0];
            default: txd_d = 1'b1;
        endcase

        wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

        case ({push, pop})
            2'b10:   level_d = level_q + LEVEL_ONE;
            2'b01:   level_d = level_q - LEVEL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge c) begin
        if (r) begin
            state_q  <= IDLE;
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            level_q  <= level_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge c) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at CLK_DIV=4, FIFO_AW=2: directed vectors, line decoding and a queue-based reference model.
module tb_uart_tx_fifo;

    localparam int CLK_DIV = 4;
    localparam int FIFO_AW = 2;
    localparam int DEPTH   = 4;
    localparam int FRAME   = 10 * CLK_DIV;

    logic       c = 1'b0;
    logic       r;
    logic [7:0] wdata;
    logic       wvalid;
    logic       wready;
    logic       txd;
    logic       busy;
    logic [2:0] level;

    uart_tx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_AW(FIFO_AW)) dut (
        .c      (c),
        .r      (r),
        .wdata  (wdata),
        .wvalid (wvalid),
        .wready (wready),
        .txd    (txd),
        .busy   (busy),
        .level  (level)
    );

    always #5 c = ~c;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic txd_log[$];
    logic busy_log[$];
    int   level_log[$];
    logic a_wready;

    // Reference model: bytes waiting in the FIFO, plus the edge at which the current frame was popped.
    logic [7:0] mq[$];
    bit         m_active;
    bit         m_frame_valid;
    int         m_pop_edge;
    logic [7:0] m_cur;
    logic       e_txd;
    logic       e_busy;
    logic       e_wready;
    int         e_level;

    logic [7:0] rx_bytes[$];
    int         rx_starts[$];

    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] d;
        logic       wr;
        int         lv;
        logic       b;
        logic       t;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc - 1);
        end
    endtask

    // Bit k of a frame: 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    task automatic model_edge(input logic rr, input logic vv, input logic [7:0] dd, input int n);
        int  pre_size;
        bit  do_pop;
        bit  accept;
        if (rr) begin
            mq.delete();
            m_active      = 1'b0;
            m_frame_valid = 1'b0;
            e_txd         = 1'b1;
        end else begin
            e_txd = 1'b1;
            if (m_frame_valid && n >= m_pop_edge + 1 && n <= m_pop_edge + FRAME)
                e_txd = frame_bit(m_cur, (n - m_pop_edge - 1) / CLK_DIV);
            pre_size = mq.size();
            do_pop   = 1'b0;
            if (!m_active) begin
                if (pre_size > 0) do_pop = 1'b1;
            end else if (n == m_pop_edge + FRAME) begin
                if (pre_size > 0) do_pop = 1'b1;
                else m_active = 1'b0;
            end
            accept = vv && (pre_size < DEPTH);
            if (do_pop) begin
                m_cur         = mq.pop_front();
                m_pop_edge    = n;
                m_active      = 1'b1;
                m_frame_valid = 1'b1;
            end
            if (accept) mq.push_back(dd);
        end
        e_level  = mq.size();
        e_wready = (e_level != DEPTH);
        e_busy   = m_active || (e_level != 0);
    endtask

    task automatic step(input logic rr, input logic vv, input logic [7:0] dd);
        r      = rr;
        wvalid = vv;
        wdata  = dd;
        @(posedge c);
        model_edge(rr, vv, dd, cyc);
        @(negedge c);
        txd_log.push_back(txd);
        busy_log.push_back(busy);
        level_log.push_back(int'(level));
        a_wready = wready;
        cyc++;
        chk("model_txd", txd, e_txd);
        chk("model_level", level, e_level);
        chk("model_busy", busy, e_busy);
        chk("model_wready", wready, e_wready);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic drain(input string name, input int bound);
        int k;
        k = 0;
        while (busy && k < bound) begin
            step(1'b0, 1'b0, 8'h00);
            k++;
        end
        chk(name, busy, 0);
        idle(3);
    endtask

    // Independent line receiver: finds start bits and samples each bit mid-cell.
    task automatic decode_line(input int from, input int upto);
        int         i;
        logic [7:0] b;
        rx_bytes.delete();
        rx_starts.delete();
        i = from;
        while (i <= upto && i + FRAME - 1 < txd_log.size()) begin
            if (txd_log[i] == 1'b0) begin
                for (int k = 0; k < 8; k++)
                    b[k] = txd_log[i + CLK_DIV * (k + 1) + CLK_DIV / 2];
                chk("stop_bit", txd_log[i + CLK_DIV * 9 + CLK_DIV / 2], 1);
                rx_bytes.push_back(b);
                rx_starts.push_back(i);
                i += FRAME;
            end else begin
                i++;
            end
        end
    endtask

    initial begin
        int         e;
        int         f0;
        int         acc_edge;
        int         nlow;
        bit         sent;
        logic [9:0] a5_bits;
        logic [7:0] exp_bytes[$];
        logic       hold_v;
        logic [7:0] hold_d;
        logic       rv;
        logic       vv;
        logic [7:0] dv;

        tbl[0] = '{1'b0, 1'b1, 8'h01, 1'b1, 1, 1'b1, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 8'h02, 1'b1, 1, 1'b1, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 8'h03, 1'b1, 2, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 8'h04, 1'b1, 3, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 8'h05, 1'b0, 4, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 8'h06, 1'b0, 4, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 8'h06, 1'b0, 4, 1'b1, 1'b1};

        r        = 1'b1;
        wvalid   = 1'b0;
        wdata    = 8'h00;
        a_wready = 1'b0;
        m_active = 1'b0;
        m_frame_valid = 1'b0;
        m_pop_edge = 0;
        m_cur    = 8'h00;
        @(negedge c);

        // Reset
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk("reset_txd", txd, 1);
        chk("reset_wready", wready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_level", level, 0);
        idle(3);

        // Single byte 0xA5
        a5_bits = {1'b1, 8'hA5, 1'b0};
        e = cyc;
        step(1'b0, 1'b1, 8'hA5);
        idle(45);
        chk("a5_pre_start", txd_log[e + 1], 1);
        for (int k = 0; k < FRAME; k++)
            chk("a5_frame", txd_log[e + 2 + k], a5_bits[k / CLK_DIV]);
        chk("a5_busy_e40", busy_log[e + 40], 1);
        chk("a5_busy_e42", busy_log[e + 42], 0);

        // Fill and backpressure
        f0 = cyc;
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].d);
            chk("tbl_wready", wready, tbl[i].wr);
            chk("tbl_level", level, tbl[i].lv);
            chk("tbl_busy", busy, tbl[i].b);
            chk("tbl_txd", txd, tbl[i].t);
        end
        sent = 1'b0;
        acc_edge = -1;
        for (int i = 0; i < 200 && !sent; i++) begin
            if (a_wready) begin
                sent = 1'b1;
                acc_edge = cyc;
            end
            step(1'b0, 1'b1, 8'h06);
        end
        chk("fill_06_accepted", sent, 1);
        chk("fill_06_edge", acc_edge - f0, 42);
        drain("fill_drain_timeout", 400);
        decode_line(f0, cyc - 1);
        chk("fill_frame_count", rx_bytes.size(), 6);
        for (int i = 0; i < rx_bytes.size() && i < 6; i++)
            chk("fill_byte", rx_bytes[i], i + 1);
        for (int i = 0; i + 1 < rx_starts.size(); i++)
            chk("b2b_spacing", rx_starts[i + 1] - rx_starts[i], FRAME);

        // Push and pop on the same edge
        e = cyc;
        step(1'b0, 1'b1, 8'hAA);
        idle(1);
        step(1'b0, 1'b1, 8'hB1);
        idle(38);
        chk("simul_level_before", level, 1);
        step(1'b0, 1'b1, 8'hC2);
        chk("simul_level_after", level, 1);
        drain("simul_drain_timeout", 200);
        decode_line(e, cyc - 1);
        exp_bytes = '{8'hAA, 8'hB1, 8'hC2};
        chk("simul_frame_count", rx_bytes.size(), 3);
        for (int i = 0; i < rx_bytes.size() && i < 3; i++)
            chk("simul_byte", rx_bytes[i], exp_bytes[i]);
        for (int i = 0; i + 1 < rx_starts.size(); i++)
            chk("simul_spacing", rx_starts[i + 1] - rx_starts[i], FRAME);

        // Reset during data bit 3 of 0xFF with two bytes queued
        e = cyc;
        step(1'b0, 1'b1, 8'hFF);
        idle(1);
        step(1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b1, 8'h22);
        idle(15);
        chk("midrst_queued", level, 2);
        chk("midrst_bit3_high", txd_log[e + 18], 1);
        step(1'b1, 1'b0, 8'h00);
        chk("midrst_txd", txd, 1);
        chk("midrst_level", level, 0);
        chk("midrst_busy", busy, 0);
        e = cyc;
        idle(60);
        nlow = 0;
        for (int k = e; k < cyc; k++)
            if (txd_log[k] == 1'b0 || busy_log[k] == 1'b1) nlow++;
        chk("midrst_quiet", nlow, 0);
        e = cyc;
        step(1'b0, 1'b1, 8'h00);
        drain("midrst_drain_timeout", 100);
        decode_line(e, cyc - 1);
        chk("midrst_frame_count", rx_bytes.size(), 1);
        if (rx_bytes.size() > 0) chk("midrst_byte", rx_bytes[0], 0);

        // Random traffic against the reference model
        hold_v = 1'b0;
        hold_d = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            rv = ($urandom_range(0, 399) == 0);
            if (hold_v) begin
                vv = 1'b1;
                dv = hold_d;
            end else begin
                vv = ($urandom_range(0, 99) < 35);
                dv = 8'($urandom);
            end
            hold_v = vv && !a_wready && !rv;
            hold_d = dv;
            step(rv, vv, dv);
        end
        drain("random_drain_timeout", 400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
